// File: rtl/mux2way_arbiter.sv
// ---------------------------------------------------------------------------
// mux2way_arbiter
//
// Round-robin arbiter and sequencer for one shared WIDTH-bit 2:1 data mux.
// Two requesters (port 0, port 1) get ownership one burst at a time. The
// owner's words are registered onto `out` with a one-cycle `out_valid` pulse
// per transfer.
//
// Parameters:
//   WIDTH      data width of each requester and of the output
//   MAX_BURST  maximum transfers per grant before forced release (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   req0/req1  port request; the port's data is offered while high
//   last0/1    final beat of the port's burst, sampled only on its transfer
//   data0/1    port data
//   gnt0/gnt1  port owns the mux (registered, mutually exclusive)
//   sel        mux select, 0 = data0, 1 = data1 (registered)
//   out        registered mux output
//   out_valid  out holds a new word this cycle
// ---------------------------------------------------------------------------
module mux2way_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             last0,
    input  logic             last1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    // Just wide enough to hold MAX_BURST.
    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);
    localparam logic [BeatW:0] BeatMax = (BeatW + 1)'(MAX_BURST);
    localparam logic [BeatW:0] BeatOne = (BeatW + 1)'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_prio;     // 0: port 0 wins a tie in idle
    logic [BeatW-1:0]   r_beat;
    logic               r_sel;
    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;

    logic               w_own0;
    logic               w_own1;
    logic               w_owned;
    logic               w_req_own;
    logic               w_req_other;
    logic               w_last_own;
    logic               w_xfer;
    logic [BeatW:0]     w_beat_inc;
    logic               w_at_limit;
    logic               w_release;
    logic               w_forced;

    // Owner-relative view of the inputs; the non-owner's last/data never matter.
    always_comb begin
        w_own0      = (r_state == StOwn0);
        w_own1      = (r_state == StOwn1);
        w_owned     = w_own0 | w_own1;
        w_req_own   = (w_own0 & req0) | (w_own1 & req1);
        w_req_other = w_own0 ? req1 : req0;
        w_last_own  = (w_own0 & last0) | (w_own1 & last1);
        w_xfer      = w_owned & w_req_own;
        w_beat_inc  = {1'b0, r_beat} + BeatOne;
        w_at_limit  = (w_beat_inc == BeatMax);
        // One release per edge, even when last and the burst limit coincide.
        w_release   = w_owned & (~w_req_own | (w_xfer & (w_last_own | w_at_limit)));
        // A burst that ended on its own (last) is not a limit-forced release.
        w_forced    = w_xfer & w_at_limit & ~w_last_own;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (req0 && req1) begin
                    w_state_next = r_prio ? StOwn1 : StOwn0;
                end else if (req0) begin
                    w_state_next = StOwn0;
                end else if (req1) begin
                    w_state_next = StOwn1;
                end
            end
            StOwn0: begin
                if (w_release) begin
                    if (req1) begin
                        w_state_next = StOwn1;
                    end else if (w_forced) begin
                        w_state_next = StOwn0;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            StOwn1: begin
                if (w_release) begin
                    if (req0) begin
                        w_state_next = StOwn0;
                    end else if (w_forced) begin
                        w_state_next = StOwn1;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath, priority and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio      <= 1'b0;
            r_beat      <= '0;
            r_sel       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out <= w_own1 ? data1 : data0;
            end

            if (w_release) begin
                r_prio <= w_own0;   // hand priority to the other port
                r_beat <= '0;
            end else if (w_xfer) begin
                r_beat <= w_beat_inc[BeatW-1:0];
            end

            // sel follows the owner and holds through idle.
            if (w_state_next == StOwn0) begin
                r_sel <= 1'b0;
            end else if (w_state_next == StOwn1) begin
                r_sel <= 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        gnt0      = (r_state == StOwn0);
        gnt1      = (r_state == StOwn1);
        sel       = r_sel;
        out       = r_out;
        out_valid = r_out_valid;
    end

endmodule

// File: tb/tb_mux2way_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2way_arbiter
//
// Two arbiter instances: unit 0 with MAX_BURST=4, unit 1 with MAX_BURST=2.
// Each stimulus cycle names the port expected to own the mux; grants and sel
// are checked against that, and every expected transfer word is queued and
// compared when the unit raises out_valid.
// ---------------------------------------------------------------------------
module tb_mux2way_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v   = 2'b11;
    logic [1:0]  req0_v  = 2'b00;
    logic [1:0]  req1_v  = 2'b00;
    logic [1:0]  last0_v = 2'b00;
    logic [1:0]  last1_v = 2'b00;
    logic [15:0] d0_a [2];
    logic [15:0] d1_a [2];
    logic [1:0]  gnt0_v;
    logic [1:0]  gnt1_v;
    logic [1:0]  sel_v;
    logic [1:0]  ov_v;
    logic [15:0] out_a [2];

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    mux2way_arbiter #(.WIDTH(16), .MAX_BURST(4)) u_dut0 (
        .clk       (clk),
        .reset     (rst_v[0]),
        .req0      (req0_v[0]),
        .req1      (req1_v[0]),
        .last0     (last0_v[0]),
        .last1     (last1_v[0]),
        .data0     (d0_a[0]),
        .data1     (d1_a[0]),
        .gnt0      (gnt0_v[0]),
        .gnt1      (gnt1_v[0]),
        .sel       (sel_v[0]),
        .out       (out_a[0]),
        .out_valid (ov_v[0])
    );

    mux2way_arbiter #(.WIDTH(16), .MAX_BURST(2)) u_dut1 (
        .clk       (clk),
        .reset     (rst_v[1]),
        .req0      (req0_v[1]),
        .req1      (req1_v[1]),
        .last0     (last0_v[1]),
        .last1     (last1_v[1]),
        .data0     (d0_a[1]),
        .data1     (d1_a[1]),
        .gnt0      (gnt0_v[1]),
        .gnt1      (gnt1_v[1]),
        .sel       (sel_v[1]),
        .out       (out_a[1]),
        .out_valid (ov_v[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input int u, input logic [15:0] d);
        if (u == 0) exp_q0.push_back(d);
        else        exp_q1.push_back(d);
    endtask

    // One clock of stimulus on unit u. own: 0 = idle, 1 = port 0, 2 = port 1,
    // i.e. who must hold the grant during this cycle.
    task automatic step(input int u, input logic r0, input logic r1, input logic l0,
                        input logic l1, input logic [15:0] d0, input logic [15:0] d1,
                        input int own);
        req0_v[u]  = r0;
        req1_v[u]  = r1;
        last0_v[u] = l0;
        last1_v[u] = l1;
        d0_a[u]    = d0;
        d1_a[u]    = d1;
        check_eq($sformatf("u%0d_gnt0", u), 32'(gnt0_v[u]), 32'(own == 1));
        check_eq($sformatf("u%0d_gnt1", u), 32'(gnt1_v[u]), 32'(own == 2));
        if (own != 0) check_eq($sformatf("u%0d_sel", u), 32'(sel_v[u]), 32'(own == 2));
        if (own == 1 && r0) push_exp(u, d0);
        if (own == 2 && r1) push_exp(u, d1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each valid word against the oldest expected one.
    always @(negedge clk) begin
        if (ov_v[0] === 1'b1) begin
            if (exp_q0.size() == 0) check_eq("u0_unexpected_valid", 32'd1, 32'd0);
            else                    check_eq("u0_out", 32'(out_a[0]), 32'(exp_q0.pop_front()));
        end
        if (ov_v[1] === 1'b1) begin
            if (exp_q1.size() == 0) check_eq("u1_unexpected_valid", 32'd1, 32'd0);
            else                    check_eq("u1_out", 32'(out_a[1]), 32'(exp_q1.pop_front()));
        end
    end

    function automatic logic [15:0] rnd();
        return 16'($urandom);
    endfunction

    initial begin
        for (int u = 0; u < 2; u++) begin
            d0_a[u] = '0;
            d1_a[u] = '0;
        end

        // Reset held two cycles while both ports request.
        req0_v[0] = 1'b1;
        req1_v[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_gnt0", 32'(gnt0_v[0]), 32'd0);
            check_eq("rst_gnt1", 32'(gnt1_v[0]), 32'd0);
            check_eq("rst_out", 32'(out_a[0]), 32'd0);
            check_eq("rst_ov", 32'(ov_v[0]), 32'd0);
            check_eq("rst_sel", 32'(sel_v[0]), 32'd0);
        end
        rst_v = 2'b00;

        // First cycle out of reset: idle, port 0 wins the tie; then drop.
        step(0, 1, 1, 0, 0, rnd(), rnd(), 0);
        step(0, 0, 0, 0, 0, rnd(), rnd(), 1);   // no transfer, release, prio -> 1
        step(0, 0, 0, 0, 0, rnd(), rnd(), 0);

        // Single three-beat burst on port 0.
        step(0, 1, 0, 0, 0, rnd(), rnd(), 0);
        step(0, 1, 0, 0, 0, 16'h0011, rnd(), 1);
        step(0, 1, 0, 0, 0, 16'h0022, rnd(), 1);
        step(0, 1, 0, 1, 0, 16'h0033, rnd(), 1); // last -> idle, prio -> 1
        step(0, 0, 0, 0, 0, rnd(), rnd(), 0);
        check_eq("burst_idle_sel", 32'(sel_v[0]), 32'd0);
        check_eq("burst_out_hold", 32'(out_a[0]), 32'h0033);
        check_eq("burst_ov_low", 32'(ov_v[0]), 32'd0);

        // Early drop on port 1 after one beat; port 1 data ignored when port 0 owns.
        step(0, 0, 1, 0, 0, rnd(), rnd(), 0);
        step(0, 0, 1, 0, 0, rnd(), rnd(), 2);
        step(0, 0, 0, 0, 0, rnd(), rnd(), 2);   // release -> idle, prio -> 0
        step(0, 0, 0, 0, 0, rnd(), rnd(), 0);
        check_eq("drop_idle_sel_hold", 32'(sel_v[0]), 32'd1);

        // Contention: both request forever, bursts of 4 alternate with no gap.
        step(0, 1, 1, 0, 0, rnd(), rnd(), 0);
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 1, 0, 0, rnd(), rnd(), ((k / 4) % 2 == 0) ? 1 : 2);
            check_eq("contend_ov", 32'(ov_v[0]), 32'd1);
        end
        step(0, 0, 0, 0, 0, rnd(), rnd(), 1);   // release -> idle, prio -> 1
        step(0, 0, 0, 0, 0, rnd(), rnd(), 0);

        // Reset during beat 2 of a port 1 burst.
        step(0, 0, 1, 0, 0, rnd(), rnd(), 0);
        step(0, 0, 1, 0, 0, rnd(), rnd(), 2);
        rst_v[0]  = 1'b1;
        req1_v[0] = 1'b1;
        d1_a[0]   = rnd();
        check_eq("midrst_pre_gnt1", 32'(gnt1_v[0]), 32'd1);
        @(posedge clk);
        #1;
        check_eq("midrst_gnt0", 32'(gnt0_v[0]), 32'd0);
        check_eq("midrst_gnt1", 32'(gnt1_v[0]), 32'd0);
        check_eq("midrst_out", 32'(out_a[0]), 32'd0);
        check_eq("midrst_ov", 32'(ov_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        step(0, 1, 1, 0, 0, rnd(), rnd(), 0);   // prio back to 0 -> port 0
        step(0, 1, 1, 0, 0, rnd(), rnd(), 1);
        step(0, 0, 0, 0, 0, rnd(), rnd(), 1);
        step(0, 0, 0, 0, 0, rnd(), rnd(), 0);

        // Unit 1, MAX_BURST=2: last0 on the limit beat with port 1 waiting.
        step(1, 1, 1, 0, 0, rnd(), rnd(), 0);
        step(1, 1, 1, 0, 0, rnd(), rnd(), 1);
        step(1, 1, 1, 1, 0, rnd(), rnd(), 1);   // single release -> port 1
        step(1, 1, 1, 0, 0, rnd(), rnd(), 2);
        step(1, 1, 1, 0, 0, rnd(), rnd(), 2);   // limit -> port 0 next
        step(1, 1, 1, 0, 0, rnd(), rnd(), 1);
        step(1, 1, 0, 0, 0, rnd(), rnd(), 1);   // limit, port 1 idle -> port 0 again
        step(1, 1, 0, 0, 0, rnd(), rnd(), 1);
        step(1, 0, 0, 0, 0, rnd(), rnd(), 1);   // release -> idle, prio -> 1
        step(1, 0, 0, 0, 0, rnd(), rnd(), 0);
        step(1, 1, 1, 0, 0, rnd(), rnd(), 0);   // tie goes to port 1
        step(1, 0, 0, 0, 0, rnd(), rnd(), 2);
        step(1, 0, 0, 0, 0, rnd(), rnd(), 0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("u0_queue_empty", 32'(exp_q0.size()), 32'd0);
        check_eq("u1_queue_empty", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux2way_arbiter.md
Name: mux2way_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one WIDTH-bit 2-way data mux between two requesters (port 0, port 1).
- Grants ownership per burst, drives the mux select, and registers the selected word with a one-cycle valid pulse.
- Sits in front of the shared datapath bus, e.g. a register-file write port or memory port, in the sequential processor.

Parameters:
- WIDTH, 16, data width of each requester and of the output.
- MAX_BURST, 4, maximum transfers per grant before forced release; legal values are 1 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 requests the mux and data0 is offered.
- req1  input  1  port 1 requests the mux and data1 is offered.
- last0  input  1  final beat of port 0 burst; sampled only on a port 0 transfer.
- last1  input  1  final beat of port 1 burst; sampled only on a port 1 transfer.
- data0  input  WIDTH  port 0 data.
- data1  input  WIDTH  port 1 data.
- gnt0  output  1  port 0 owns the mux (registered).
- gnt1  output  1  port 1 owns the mux (registered).
- sel  output  1  mux select: 0 selects data0, 1 selects data1 (registered).
- out  output  WIDTH  registered mux output.
- out_valid  output  1  out holds a new word this cycle.

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-high.
- Reset values: state=IDLE, gnt0=0, gnt1=0, sel=0, out=0, out_valid=0, prio=0 (port 0 preferred), beat=0.
- Reset asserted mid-burst: everything returns to the reset values at the next edge. No transfer completes in that cycle.
- States:
  - IDLE: no owner.
  - OWN0: gnt0=1, sel=0.
  - OWN1: gnt1=1, sel=1.
- gnt0 and gnt1 are never both 1.
- In IDLE, sel holds its previous value.
- IDLE transitions:
  - Only req0 → OWN0.
  - Only req1 → OWN1.
  - Both requesting → the port named by prio.
  - Neither → stay in IDLE.
- Grant latency: a request first seen in IDLE at cycle N gives gnt high at N+1. The first transfer can occur at N+1.
- Transfer: in OWNx, a cycle with reqx=1 is a transfer.
  - At the next edge: out<=datax, out_valid<=1, beat<=beat+1.
  - In all other cycles out_valid<=0 and out holds its value.
- Release: in OWNx, release at the edge when any of these holds:
  - reqx=0 (no transfer that cycle);
  - a transfer with lastx=1;
  - a transfer with beat+1 == MAX_BURST.
- On release:
  - prio <= other port.
  - beat <= 0.
  - Next state, in priority order:
    - other port requesting → OWN other, with no idle bubble;
    - release was forced by MAX_BURST and reqx=1 → OWNx again;
    - otherwise → IDLE.
- Fairness: under continuous requests from both ports, ownership alternates every burst. Neither port waits more than MAX_BURST+1 cycles after its first unserved request.
- beat width is the minimum needed to hold MAX_BURST. beat never exceeds MAX_BURST-1 while owned.
- Inputs of the non-owning port are ignored, including its data and last.
- Simultaneous last and MAX_BURST on one transfer: a single release, with no double prio toggle.

Test Plan:
- Reset then idle: assert reset 2 cycles with req0=req1=1 → gnt0=gnt1=0, out=0, out_valid=0. After reset deasserts, gnt0=1 one cycle later.
- Single burst: req0=1 for 3 cycles with data0=0x0011/0x0022/0x0033 and last0 on the third → gnt0 high 3 cycles. out shows 0x0011, 0x0022, 0x0033 each one cycle after its transfer, out_valid high for 3 consecutive cycles. Then IDLE with sel=0.
- Contention alternation: req0=req1=1 continuously, last never asserted, MAX_BURST=4 → 4 beats to port 0, then 4 beats to port 1, and so on. sel toggles with no gap cycle, and out_valid stays continuously 1 after the first grant.
- Early drop: in OWN1, deassert req1 after 1 beat with req0=0 → next state IDLE, prio=0. Re-asserting both then grants port 0.
- Last-plus-limit collision: MAX_BURST=2, port 0 asserts last0 on beat 2 while req1=1 → exactly one release, gnt1=1 next cycle, prio=1→... port 0 is next after port 1's burst.
- Mid-burst reset: reset during beat 2 of OWN1 → next cycle gnt1=0, out=0, out_valid=0, state IDLE, prio=0.
